// File: rtl/crop_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : crop_frame_writer
// Brief    : Extracts a clamped OUT_ROWS x OUT_COLS window from a raster-order
//            pixel stream, forwards it over AXI-Stream and tracks its peak.
// Revision : 1.0 - initial release
// ============================================================================
module crop_frame_writer #(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int IN_ROWS         = 20,
    parameter int IN_COLS         = 20,
    parameter int OUT_ROWS        = 10,
    parameter int OUT_COLS        = 10
) (
    input  logic                                            clk,
    input  logic                                            srst,
    input  logic                                            ap_start,
    output logic                                            ap_done,
    output logic                                            ap_ready,
    output logic                                            ap_idle,
    input  logic [((IN_ROWS > 1) ? $clog2(IN_ROWS) : 1)-1:0] crop_row,
    input  logic [((IN_COLS > 1) ? $clog2(IN_COLS) : 1)-1:0] crop_col,
    input  logic                                            s_axis_tvalid,
    output logic                                            s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0]                      s_axis_tdata,
    output logic                                            m_axis_tvalid,
    input  logic                                            m_axis_tready,
    output logic [PIXEL_BIT_WIDTH-1:0]                      m_axis_tdata,
    output logic [PIXEL_BIT_WIDTH-1:0]                      norm_denominator
);

    localparam int c_ROW_W = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
    localparam int c_COL_W = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;

    localparam logic [c_ROW_W-1:0] c_MAX_CROP_ROW = c_ROW_W'(IN_ROWS - OUT_ROWS);
    localparam logic [c_COL_W-1:0] c_MAX_CROP_COL = c_COL_W'(IN_COLS - OUT_COLS);
    localparam logic [c_ROW_W-1:0] c_LAST_ROW     = c_ROW_W'(IN_ROWS - 1);
    localparam logic [c_COL_W-1:0] c_LAST_COL     = c_COL_W'(IN_COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                     r_state;
    logic [c_ROW_W-1:0]         r_crop_row;
    logic [c_COL_W-1:0]         r_crop_col;
    logic [c_ROW_W-1:0]         r_row;
    logic [c_COL_W-1:0]         r_col;
    logic [PIXEL_BIT_WIDTH-1:0] r_max;
    logic                       r_m_valid;
    logic [PIXEL_BIT_WIDTH-1:0] r_m_data;
    logic [PIXEL_BIT_WIDTH-1:0] r_norm;

    logic        w_tready;
    logic        w_accept;
    logic        w_last_beat;
    logic        w_in_win;
    logic [31:0] w_row32;
    logic [31:0] w_col32;
    logic [31:0] w_crop_row32;
    logic [31:0] w_crop_col32;

    // Window bounds are compared at 32 bits so crop+OUT-1 can never wrap.
    assign w_row32      = 32'(r_row);
    assign w_col32      = 32'(r_col);
    assign w_crop_row32 = 32'(r_crop_row);
    assign w_crop_col32 = 32'(r_crop_col);

    assign w_in_win = (w_row32 >= w_crop_row32) && (w_row32 < w_crop_row32 + 32'(OUT_ROWS)) &&
                      (w_col32 >= w_crop_col32) && (w_col32 < w_crop_col32 + 32'(OUT_COLS));

    assign w_tready    = (r_state == S_STREAM) && (!r_m_valid || m_axis_tready);
    assign w_accept    = s_axis_tvalid && w_tready;
    assign w_last_beat = (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);

    assign s_axis_tready    = w_tready;
    assign m_axis_tvalid    = r_m_valid;
    assign m_axis_tdata     = r_m_data;
    assign norm_denominator = r_norm;
    assign ap_idle          = (r_state == S_IDLE);
    assign ap_ready         = (r_state == S_IDLE);
    assign ap_done          = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state    <= S_IDLE;
            r_crop_row <= '0;
            r_crop_col <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_max      <= '0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_norm     <= PIXEL_BIT_WIDTH'(1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_crop_row <= (crop_row > c_MAX_CROP_ROW) ? c_MAX_CROP_ROW : crop_row;
                        r_crop_col <= (crop_col > c_MAX_CROP_COL) ? c_MAX_CROP_COL : crop_col;
                        r_row      <= '0;
                        r_col      <= '0;
                        r_max      <= '0;
                        r_state    <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_accept) begin
                        if (r_col == c_LAST_COL) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                        if (w_last_beat) begin
                            r_state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    // Wait until the final cropped beat has left the output register.
                    if (!r_m_valid || m_axis_tready) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_norm  <= (r_max == '0) ? PIXEL_BIT_WIDTH'(1) : r_max;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_accept && w_in_win) begin
                r_m_valid <= 1'b1;
                r_m_data  <= s_axis_tdata;
                if (s_axis_tdata > r_max) begin
                    r_max <= s_axis_tdata;
                end
            end else if (r_m_valid && m_axis_tready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crop_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_crop_frame_writer
// Brief    : Scoreboard bench for crop_frame_writer on a 4x4 -> 2x2 crop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crop_frame_writer;

    logic       clk;
    logic       srst;
    logic       ap_start;
    logic       ap_done;
    logic       ap_ready;
    logic       ap_idle;
    logic [1:0] crop_row;
    logic [1:0] crop_col;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [9:0] s_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic [9:0] m_axis_tdata;
    logic [9:0] norm_denominator;

    int n_vec;
    int n_err;
    int done_cnt;
    int exp_q[$];

    crop_frame_writer #(
        .PIXEL_BIT_WIDTH (10),
        .IN_ROWS         (4),
        .IN_COLS         (4),
        .OUT_ROWS        (2),
        .OUT_COLS        (2)
    ) u_dut (
        .clk              (clk),
        .srst             (srst),
        .ap_start         (ap_start),
        .ap_done          (ap_done),
        .ap_ready         (ap_ready),
        .ap_idle          (ap_idle),
        .crop_row         (crop_row),
        .crop_col         (crop_col),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tdata     (s_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .norm_denominator (norm_denominator)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every completed handshake.
    always @(negedge clk) begin
        if (!srst) begin
            if (ap_done) done_cnt++;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_beat_q_size", 32'(exp_q.size()), 32'd1);
                end else begin
                    check_eq("tdata", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic push_expected(input int cr, input int cc, input bit zero, output int exp_norm);
        int er;
        int ec;
        int p;
        er = (cr > 2) ? 2 : cr;
        ec = (cc > 2) ? 2 : cc;
        exp_norm = 0;
        for (int r = er; r < er + 2; r++) begin
            for (int c = ec; c < ec + 2; c++) begin
                p = zero ? 0 : r * 4 + c;
                exp_q.push_back(p);
                if (p > exp_norm) exp_norm = p;
            end
        end
        if (exp_norm == 0) exp_norm = 1;
    endtask

    task automatic start_frame(input int cr, input int cc);
        @(posedge clk); #1;
        check_eq("ready_before_start", 32'(ap_ready), 32'd1);
        ap_start = 1'b1;
        crop_row = 2'(cr);
        crop_col = 2'(cc);
        @(posedge clk); #1;
        ap_start = 1'b0;
        check_eq("idle_in_stream", 32'(ap_idle), 32'd0);
    endtask

    task automatic run_frame(input int cr, input int cc, input bit zero, input bit stall, input bit glitch);
        int  exp_norm;
        int  idx;
        int  budget;
        int  stall_cnt;
        int  done0;
        bit  acc;
        push_expected(cr, cc, zero, exp_norm);
        done0 = done_cnt;
        start_frame(cr, cc);
        idx = 0; budget = 0; stall_cnt = 0;
        while (idx < 16 && budget < 200) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = zero ? 10'd0 : 10'(idx);
            if (glitch && idx == 3) begin
                ap_start = 1'b1; crop_row = 2'd2; crop_col = 2'd2;
            end else begin
                ap_start = 1'b0;
            end
            m_axis_tready = !(stall && stall_cnt < 5 && m_axis_tvalid);
            if (!m_axis_tready) stall_cnt++;
            @(negedge clk);
            if (!m_axis_tready) begin
                check_eq("stall_tdata", 32'(m_axis_tdata), 32'd5);
                check_eq("stall_s_tready", 32'(s_axis_tready), 32'd0);
            end
            acc = s_axis_tready;
            @(posedge clk); #1;
            if (acc) idx++;
            budget++;
        end
        s_axis_tvalid = 1'b0;
        ap_start      = 1'b0;
        m_axis_tready = 1'b1;
        if (budget >= 200) check_eq("stream_timeout_beats", 32'(idx), 32'd16);
        budget = 0;
        while (done_cnt == done0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check_eq("done_seen", 32'(done_cnt - done0), 32'd1);
        @(negedge clk);
        check_eq("s_tready_after", 32'(s_axis_tready), 32'd0);
        check_eq("ap_ready_after", 32'(ap_ready), 32'd1);
        check_eq("ap_idle_after", 32'(ap_idle), 32'd1);
        check_eq("norm_denominator", 32'(norm_denominator), 32'(exp_norm));
        check_eq("beats_outstanding", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("done_pulse_count", 32'(done_cnt - done0), 32'd1);
    endtask

    task automatic abort_frame();
        int  exp_norm;
        int  idx;
        int  budget;
        int  done0;
        bit  acc;
        push_expected(0, 0, 1'b0, exp_norm);
        done0 = done_cnt;
        start_frame(0, 0);
        idx = 0; budget = 0;
        while (idx < 6 && budget < 100) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 10'(idx);
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk); #1;
            if (acc) idx++;
            budget++;
        end
        check_eq("abort_beats_fed", 32'(idx), 32'd6);
        s_axis_tvalid = 1'b0;
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        check_eq("abort_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_eq("abort_ap_idle", 32'(ap_idle), 32'd1);
        check_eq("abort_norm_kept_reset", 32'(norm_denominator), 32'd1);
        exp_q.delete();
        repeat (6) @(negedge clk);
        check_eq("abort_no_done", 32'(done_cnt - done0), 32'd0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; done_cnt = 0;
        srst = 1'b1; ap_start = 1'b0; crop_row = '0; crop_col = '0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;
        @(negedge clk);
        check_eq("rst_ap_idle", 32'(ap_idle), 32'd1);
        check_eq("rst_ap_ready", 32'(ap_ready), 32'd1);
        check_eq("rst_ap_done", 32'(ap_done), 32'd0);
        check_eq("rst_s_tready", 32'(s_axis_tready), 32'd0);
        check_eq("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_eq("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
        check_eq("rst_norm", 32'(norm_denominator), 32'd1);

        run_frame(1, 1, 1'b0, 1'b0, 1'b0);
        run_frame(1, 1, 1'b0, 1'b1, 1'b0);
        run_frame(3, 3, 1'b0, 1'b0, 1'b0);
        run_frame(0, 0, 1'b1, 1'b0, 1'b0);
        abort_frame();
        run_frame(0, 0, 1'b0, 1'b0, 1'b0);
        run_frame(1, 1, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got time %0t, expected completion earlier", $time);
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire

// File: doc/crop_frame_writer.md
CROP_FRAME_WRITER -- requirements
Module: crop_frame_writer

Interface
REQ-001 Parameters SHALL be: PIXEL_BIT_WIDTH, default 10, pixel width; IN_ROWS, default 20, input frame rows; IN_COLS, default 20, input frame columns; OUT_ROWS, default 10, crop rows; OUT_COLS, default 10, crop columns (OUT_ROWS<=IN_ROWS, OUT_COLS<=IN_COLS).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high. Ports SHALL be:
  clk  in  1  clock, all logic on rising edge
  srst  in  1  synchronous active-high reset
  ap_start  in  1  start one frame; sampled only in IDLE
  ap_done  out  1  one-cycle pulse, frame complete; drives downstream cf_ap_done
  ap_ready  out  1  high when a new ap_start will be accepted
  ap_idle  out  1  high in IDLE
  crop_row  in  max(1,$clog2(IN_ROWS))  crop window top row, latched at ap_start
  crop_col  in  max(1,$clog2(IN_COLS))  crop window left column, latched at ap_start
  s_axis_tvalid  in  1  input pixel valid
  s_axis_tready  out  1  input pixel accepted
  s_axis_tdata  in  PIXEL_BIT_WIDTH  full-frame pixel, raster order
  m_axis_tvalid  out  1  output pixel valid
  m_axis_tready  in  1  downstream ready
  m_axis_tdata  out  PIXEL_BIT_WIDTH  cropped pixel, raster order
  norm_denominator  out  PIXEL_BIT_WIDTH  max cropped pixel of last completed frame

Function
REQ-003 FSM SHALL have states IDLE, STREAM, FLUSH, DONE.
REQ-004 IDLE: ap_idle=1, ap_ready=1, s_axis_tready=0; ap_start=1 SHALL latch crop origin, clear row/col counters and running max to 0, enter STREAM next cycle.
REQ-005 ap_start in any state other than IDLE SHALL be ignored with no effect.
REQ-006 Latched crop_row > IN_ROWS-OUT_ROWS SHALL be clamped to IN_ROWS-OUT_ROWS; crop_col likewise with IN_COLS-OUT_COLS.
REQ-007 STREAM: s_axis_tready SHALL equal (!m_axis_tvalid || m_axis_tready); a beat is accepted when s_axis_tvalid && s_axis_tready.
REQ-008 Each accepted beat SHALL advance col counter; col wrap from IN_COLS-1 to 0 SHALL increment row.
REQ-009 A beat SHALL be in-window iff crop_row<=row<=crop_row+OUT_ROWS-1 and crop_col<=col<=crop_col+OUT_COLS-1.
REQ-010 In-window beats SHALL load the single output register: m_axis_tvalid=1, m_axis_tdata=pixel on the next cycle (latency 1); out-of-window beats SHALL be discarded.
REQ-011 In-window beats SHALL update running max = max(running max, pixel), unsigned compare.
REQ-012 m_axis_tvalid SHALL clear on m_axis_tvalid && m_axis_tready unless reloaded the same cycle; m_axis_tdata SHALL be held stable while m_axis_tvalid && !m_axis_tready.
REQ-013 Acceptance of beat (IN_ROWS-1, IN_COLS-1) SHALL move STREAM to FLUSH; s_axis_tready=0 in FLUSH, DONE and IDLE.
REQ-014 FLUSH SHALL move to DONE on the cycle m_axis_tvalid is 0 or m_axis_tvalid && m_axis_tready.
REQ-015 DONE SHALL last exactly one cycle with ap_done=1, load norm_denominator = running max, or 1 if running max is 0, then enter IDLE.
REQ-016 ap_ready and ap_idle SHALL be 0 in STREAM, FLUSH, DONE.
REQ-017 Exactly OUT_ROWS*OUT_COLS output beats SHALL be emitted per frame.
REQ-018 norm_denominator SHALL hold its value from DONE until the next DONE.

Reset
REQ-019 srst SHALL force: state IDLE, ap_done=0, ap_ready=1, ap_idle=1, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, counters 0, running max 0, norm_denominator=1.
REQ-020 srst mid-frame SHALL abort the frame, drop any held output beat, and produce no ap_done; srst overrides ap_start in the same cycle.

Verification (IN 4x4, OUT 2x2, PIXEL_BIT_WIDTH 10, pixel = raster index 0..15)
REQ-021 crop (1,1), tready=1 -> outputs 5,6,9,10; norm_denominator=10; one ap_done pulse; ap_ready=1 after.
REQ-022 crop (1,1), m_axis_tready=0 for 5 cycles while tvalid=1 holding 5 -> tdata stays 5, s_axis_tready=0, outputs still 5,6,9,10, no loss.
REQ-023 crop (3,3) -> clamped to (2,2); outputs 10,11,14,15; norm_denominator=15.
REQ-024 all-zero frame, crop (0,0) -> four outputs of 0; norm_denominator=1.
REQ-025 srst after 6 accepted beats -> next cycle m_axis_tvalid=0, ap_idle=1, no ap_done; fresh ap_start with crop (0,0) -> outputs 0,1,4,5.
REQ-026 ap_start pulsed during STREAM with crop (2,2) -> ignored; frame completes with original crop values.
